// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encoding, FSM states and op-class helpers for the M-extension unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } muldiv_state_t;

    function automatic logic is_div(input muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input muldiv_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// div_iter: restoring shift-subtract divider on unsigned magnitudes, one quotient bit per iterate
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             iterate,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             count_done
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH+1:0] diff_d;

    // Trial subtract of the divisor from the shifted partial remainder; restore on borrow.
    // The dividend is shifted out of the top of the quotient register as quotient bits enter below.
    always_comb begin
        diff_d = {1'b0, rem_q, quo_q[WIDTH-1]} - {2'b0, dvs_q};
        rem_d  = diff_d[WIDTH+1] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : diff_d[WIDTH-1:0];
        quo_d  = {quo_q[WIDTH-2:0], ~diff_d[WIDTH+1]};
    end

    // Operand load and per-iteration register update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
            cnt_q <= '0;
        end else if (iterate) begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign quotient   = quo_q;
    assign remainder  = rem_q;
    // High while the final iteration is being performed this cycle
    assign count_done = cnt_q == CW'(WIDTH - 1);

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide unit with flush abort
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int W  = WIDTH;
    localparam int VD = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
    localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

    muldiv_state_t state_q, state_d;
    muldiv_op_t    op_in, op_q;

    logic                  accept, sa, sb, special, div_load;
    logic                  neg_quo_q, neg_rem_q;
    logic [W-1:0]          mag_a, mag_b, special_val, div_val, result_q;
    logic [W-1:0]          quotient, remainder;
    logic                  count_done;
    logic signed [2*W-1:0] ext_a, ext_b, product;
    logic [2*W-1:0]        pipe_q [MUL_LAT];
    logic [VD-1:0]         vld_q;

    assign op_in   = muldiv_op_t'(op);
    assign accept  = start && !flush && state_q == ST_IDLE;
    assign sa      = is_signed_a(op_in) && op_a[W-1];
    assign sb      = is_signed_b(op_in) && op_b[W-1];
    assign ext_a   = {{W{sa}}, op_a};
    assign ext_b   = {{W{sb}}, op_b};
    assign product = ext_a * ext_b;
    assign mag_a   = sa ? -op_a : op_a;
    assign mag_b   = sb ? -op_b : op_b;
    // Divide-by-zero and signed MIN_INT/-1 complete without iterating
    assign special     = op_b == '0 || (is_signed_a(op_in) && op_a == MIN_INT && op_b == '1);
    assign special_val = op_b == '0 ? (op_in[1] ? op_a : '1) : (op_in[1] ? '0 : MIN_INT);
    assign div_load    = accept && is_div(op_in) && !special;
    assign div_val     = op_q[1] ? (neg_rem_q ? -remainder : remainder)
                                 : (neg_quo_q ? -quotient : quotient);

    div_iter #(.WIDTH(W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .load       (div_load),
        .dividend   (mag_a),
        .divisor    (mag_b),
        .iterate    (state_q == ST_DIV),
        .quotient   (quotient),
        .remainder  (remainder),
        .count_done (count_done)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; flush overrides everything and returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = !is_div(op_in) ? (MUL_LAT == 1 ? ST_DONE : ST_MUL)
                                                          : (special ? ST_DONE : ST_DIV);
            ST_MUL:  if (vld_q[VD-1]) state_d = ST_DONE;
            ST_DIV:  if (count_done) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    // Outputs; multiply results come straight from the pipeline tail in the done cycle
    always_comb begin
        busy   = state_q inside {ST_MUL, ST_DIV, ST_FIX};
        done   = state_q == ST_DONE;
        result = (done && !op_q[2]) ? (op_q == OP_MUL ? pipe_q[MUL_LAT-1][W-1:0]
                                                      : pipe_q[MUL_LAT-1][2*W-1:W])
                                    : result_q;
    end

    // Operand/sign capture, multiplier valid/result pipeline and result holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= OP_MUL;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            vld_q     <= '0;
            for (int i = 0; i < MUL_LAT; i++) pipe_q[i] <= '0;
        end else begin
            vld_q <= flush ? '0 : VD'({vld_q, accept && !is_div(op_in)});
            for (int i = MUL_LAT - 1; i > 0; i--) pipe_q[i] <= pipe_q[i-1];
            if (accept) begin
                op_q      <= op_in;
                neg_quo_q <= sa ^ sb;
                neg_rem_q <= sa;
                pipe_q[0] <= product;
            end
            if (accept && is_div(op_in) && special) result_q <= special_val;
            else if (state_q == ST_FIX && !flush)   result_q <= div_val;
            else if (state_q == ST_DONE)            result_q <= result;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit with hand-computed results and latencies
module tb_muldiv_unit;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
    logic        busy, done;
    logic [2:0]  op = 3'b000;
    logic [31:0] op_a = '0, op_b = '0, result;
    int          n_chk = 0, n_err = 0;

    muldiv_unit #(.WIDTH(32), .MUL_LAT(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Issue one op, scramble operands after accept, check latency, result and single done pulse.
    // hold keeps start asserted through busy and the done cycle, which must all be ignored.
    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit hold);
        int cyc = 0;
        @(negedge clk);
        start = 1'b1; op = o; op_a = a; op_b = b;
        @(posedge clk);
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                if (!hold) start = 1'b0;
                op_a = ~a;
                op_b = b + 32'd5;
                if (lat > 1) chk({tag, " busy"}, 32'(busy), 32'd1);
            end
        end while (!done && cyc < 100);
        chk({tag, " lat"}, cyc, lat);
        chk({tag, " res"}, result, exp);
        chk({tag, " busy@done"}, 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk({tag, " pulse"}, 32'({busy, done}), 32'd0);
    endtask

    initial begin
        int seen;
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst result", result, 32'd0);
        rst = 1'b0;

        run("mul",     3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, 1'b0);
        run("mulh",    3'b001, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 2, 1'b0);
        run("mulhu",   3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 1'b0);
        run("mulhsu",  3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 2, 1'b0);
        run("mulh_min",3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 2, 1'b0);
        run("mul_lo",  3'b000, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 2, 1'b0);

        run("div",     3'b100, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 34, 1'b0);
        run("rem",     3'b110, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 34, 1'b0);
        run("div_nb",  3'b100, 32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA, 34, 1'b0);
        run("rem_nb",  3'b110, 32'd20,         32'hFFFF_FFFD, 32'd2,         34, 1'b0);
        run("divu",    3'b101, 32'd100,        32'd7,         32'd14,        34, 1'b0);
        run("remu",    3'b111, 32'd100,        32'd7,         32'd2,         34, 1'b0);
        run("remu_big",3'b111, 32'hFFFF_FFFF,  32'd10,        32'd5,         34, 1'b0);
        run("divu_ovf",3'b101, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         34, 1'b0);
        run("remu_ovf",3'b111, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 34, 1'b0);

        run("div0",    3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 1, 1'b0);
        run("rem0",    3'b110, 32'd5,          32'd0,         32'd5,         1, 1'b0);
        run("divu0",   3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1, 1'b0);
        run("div_ovf", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
        run("rem_ovf", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1, 1'b0);

        run("divu_pre",3'b101, 32'd100,        32'd7,         32'd14,        34, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'b100; op_a = 32'd1000; op_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", 32'(busy), 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            seen |= int'(done);
        end
        chk("flush no done", seen, 0);
        chk("flush keep", result, 32'd14);

        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'b100; op_a = 32'd5; op_b = 32'd0;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush+start", 32'({busy, done}), 32'd0);
        chk("flush+start keep", result, 32'd14);
        run("divu_post", 3'b101, 32'd9, 32'd2, 32'd4, 34, 1'b0);

        run("hold_div",  3'b101, 32'd77,  32'd10,        32'd7,         34, 1'b1);
        run("hold_mul",  3'b000, 32'd7,   32'hFFFF_FFFD, 32'hFFFF_FFEB, 2,  1'b1);
        run("hold_div0", 3'b100, 32'd5,   32'd0,         32'hFFFF_FFFF, 1,  1'b1);

        @(negedge clk);
        start = 1'b1; op = 3'b100; op_a = 32'hFFFF_FFEC; op_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre-rst busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst done", 32'(done), 32'd0);
        chk("async rst result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run("mul_post_rst", 3'b000, 32'd6, 32'd9, 32'd54, 2, 1'b0);
        run("div_post_rst", 3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 34, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
